// File: rtl/rf_pkg.sv
// Shared register-file definitions: default widths and ABI register indices.
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 1;
  localparam int REG_SP   = 2;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one busy bit per register plus a registered busy count.
// A new issue to an index outranks a retiring write to the same index.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic [2**ADDR_W-1:0]   busy,
  output logic [ADDR_W:0]        busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic set_eff;
  logic clr_eff;
  logic inc;
  logic dec;
  logic [ADDR_W:0] cnt_next;

  always_comb begin
    set_eff  = iss_en && !((ZERO_REG != 0) && (iss_addr == ADDR_W'(REG_ZERO)));
    clr_eff  = wr_en;
    inc      = set_eff && !busy[iss_addr];
    dec      = clr_eff && busy[wr_addr] && !(set_eff && (iss_addr == wr_addr));
    cnt_next = busy_cnt;
    if (inc && !dec && (busy_cnt < CNT_MAX)) begin
      cnt_next = busy_cnt + CNT_ONE;
    end else if (dec && !inc && (busy_cnt != '0)) begin
      cnt_next = busy_cnt - CNT_ONE;
    end
  end

  // Clear is applied before set so a same-index issue leaves the bit set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (clr_eff) busy[wr_addr] <= 1'b0;
      if (set_eff) busy[iss_addr] <= 1'b1;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/rf_bypass_sb.sv
// Multi-read-port register file with write-through bypass, RAW hazard flags
// and an unbypassed debug read port.
module rf_bypass_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_hazard,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic [ADDR_W:0]         busy_cnt,
  input  logic [ADDR_W-1:0]       dbg_sel,
  output logic [DATA_W-1:0]       dbg_data
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_eff;

  assign wr_eff = wr_en && !((ZERO_REG != 0) && (wr_addr == ZERO_IDX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else if (wr_eff) begin
      rf[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // A source being written this cycle is forwarded, so it is no longer a hazard.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              bypass;

    assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (addr == ZERO_IDX);
    assign bypass  = wr_en && (wr_addr == addr);

    assign rd_data[k*DATA_W +: DATA_W] = is_zero ? '0 :
                                         bypass  ? wr_data : rf[addr];
    assign rd_hazard[k] = busy[addr] && !bypass && !is_zero;
  end

  assign dbg_data = rf[dbg_sel];

endmodule

// File: tb/tb_rf_bypass_sb.sv
// Directed and randomized bench for rf_bypass_sb against an array/count
// reference model of the register file and scoreboard.
module tb_rf_bypass_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 2**AW;

  logic              clk;
  logic              rst_n;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_hazard;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic [AW:0]       busy_cnt;
  logic [AW-1:0]     dbg_sel;
  logic [DW-1:0]     dbg_data;

  int vectors;
  int miscompares;

  logic [DW-1:0] m_rf [DEPTH];
  bit            m_busy [DEPTH];
  int            m_cnt;

  rf_bypass_sb #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NRD      (NR),
    .ZERO_REG (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_hazard (rd_hazard),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .busy_cnt  (busy_cnt),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_rf[a];
  endfunction

  function automatic logic exp_hazard(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !(wr_en && wr_addr == a);
  endfunction

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < NR; k++) begin
      check_val($sformatf("rd_data%0d", k), rd_data[k*DW +: DW], exp_read(rd_addr[k*AW +: AW]));
      check_val($sformatf("rd_hazard%0d", k), DW'(rd_hazard[k]), DW'(exp_hazard(rd_addr[k*AW +: AW])));
    end
    check_val("busy_cnt", DW'(busy_cnt), DW'(m_cnt));
    check_val("dbg_data", dbg_data, m_rf[dbg_sel]);
  endtask

  task automatic applyStimulus(input logic rn, input logic we, input int wa, input logic [DW-1:0] wd,
                               input logic ie, input int ia, input int ra0, input int ra1, input int ds);
    @(negedge clk);
    rst_n    = rn;
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    iss_en   = ie;
    iss_addr = AW'(ia);
    rd_addr  = {AW'(ra1), AW'(ra0)};
    dbg_sel  = AW'(ds);
    #2;
  endtask

  // Reference update at the clock edge, straight from the register-file rules.
  task automatic tick();
    bit set_eff, inc, dec;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_rf[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_cnt = 0;
    end else begin
      set_eff = iss_en && (iss_addr != 0);
      inc = set_eff && !m_busy[iss_addr];
      dec = wr_en && m_busy[wr_addr] && !(set_eff && iss_addr == wr_addr);
      m_cnt = m_cnt + int'(inc) - int'(dec);
      if (m_cnt < 0) m_cnt = 0;
      if (m_cnt > DEPTH) m_cnt = DEPTH;
      if (wr_en && wr_addr != 0) begin
        m_rf[wr_addr] = wr_data;
        $display("[TB] write r%0d = %h", wr_addr, wr_data);
      end
      if (wr_en) m_busy[wr_addr] = 1'b0;
      if (set_eff) m_busy[iss_addr] = 1'b1;
    end
  endtask

  task automatic step(input logic rn, input logic we, input int wa, input logic [DW-1:0] wd,
                      input logic ie, input int ia, input int ra0, input int ra1, input int ds);
    applyStimulus(rn, we, wa, wd, ie, ia, ra0, ra1, ds);
    checkOutput();
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_rf[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0; dbg_sel = '0;

    // Reset with a concurrent write that must be discarded.
    applyStimulus(1'b0, 1'b1, 6, 32'h1111_1111, 1'b1, 6, 0, 0, 0);
    tick();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 6, 0, 6);
    check_val("rst_rd0", rd_data[DW-1:0], 32'h0);
    check_val("rst_hz", DW'(rd_hazard), 32'h0);
    check_val("rst_cnt", DW'(busy_cnt), 32'h0);
    check_val("rst_dbg", dbg_data, 32'h0);
    tick();

    // Write r5, then read it through storage and debug.
    step(1'b1, 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 5, 5, 5);
    check_val("r5_rd0", rd_data[DW-1:0], 32'hDEAD_BEEF);
    check_val("r5_dbg", dbg_data, 32'hDEAD_BEEF);
    checkOutput();
    tick();

    // Write-through on r7 while debug still sees the old value.
    applyStimulus(1'b1, 1'b1, 7, 32'h1234_5678, 1'b0, 0, 7, 5, 7);
    check_val("wt_rd0", rd_data[DW-1:0], 32'h1234_5678);
    check_val("wt_dbg", dbg_data, 32'h0);
    checkOutput();
    tick();

    // r0 ignores writes and issues.
    applyStimulus(1'b1, 1'b1, 0, 32'hFFFF_FFFF, 1'b1, 0, 0, 0, 0);
    check_val("r0_rd0", rd_data[DW-1:0], 32'h0);
    check_val("r0_hz0", DW'(rd_hazard[0]), 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
    check_val("r0_cnt", DW'(busy_cnt), 32'h0);
    check_val("r0_dbg", dbg_data, 32'h0);
    tick();

    // Issue r3, observe hazard, retire it with a bypassed write.
    step(1'b1, 1'b0, 0, 0, 1'b1, 3, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 3, 0, 3);
    check_val("iss_hz", DW'(rd_hazard[0]), 32'h1);
    check_val("iss_cnt", DW'(busy_cnt), 32'h1);
    tick();
    applyStimulus(1'b1, 1'b1, 3, 32'hA5, 1'b0, 0, 3, 0, 3);
    check_val("ret_hz", DW'(rd_hazard[0]), 32'h0);
    check_val("ret_rd0", rd_data[DW-1:0], 32'hA5);
    tick();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 3, 0, 3);
    check_val("ret_cnt", DW'(busy_cnt), 32'h0);
    tick();

    // Same-cycle retire and reissue of r3: set wins.
    step(1'b1, 1'b0, 0, 0, 1'b1, 3, 0, 0, 0);
    step(1'b1, 1'b1, 3, 32'h77, 1'b1, 3, 3, 0, 3);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 3, 0, 3);
    check_val("rei_hz", DW'(rd_hazard[0]), 32'h1);
    check_val("rei_cnt", DW'(busy_cnt), 32'h1);
    check_val("rei_dbg", dbg_data, 32'h77);
    tick();

    // Several issues, then reset together with a write to r9.
    step(1'b1, 1'b0, 0, 0, 1'b1, 1, 0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 2, 0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 4, 1, 2, 0);
    step(1'b0, 1'b1, 9, 32'h55, 1'b0, 0, 1, 4, 9);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 1, 4, 9);
    check_val("mrst_cnt", DW'(busy_cnt), 32'h0);
    check_val("mrst_dbg", dbg_data, 32'h0);
    check_val("mrst_hz", DW'(rd_hazard), 32'h0);
    tick();

    // Randomized traffic over a narrow index range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) != 0),
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)),
           DW'($urandom),
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, DEPTH - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
